// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the CPU (port 0)
// and a debug/DMA loader (port 1), with a per-tenure burst cap and fixed-latency read return.
module data_mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic                  rvalid0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  rvalid1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_WE,
   input  logic [DATA_WIDTH-1:0] mem_data_i
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] BURST_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic [CW-1:0]         burst_q, burst_d;
   logic [CW-1:0]         burst_inc_s;
   logic                  burst_last_s;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rd_port_q, rd_port_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
   logic                  acc0_s, acc1_s;

   assign acc0_s       = (state_q == OWN0) && req0;
   assign acc1_s       = (state_q == OWN1) && req1;
   assign burst_inc_s  = (burst_q == BURST_MAX) ? burst_q : (burst_q + BURST_ONE);
   assign burst_last_s = (burst_q == (BURST_MAX - BURST_ONE));

   assign gnt0    = (state_q == OWN0);
   assign gnt1    = (state_q == OWN1);
   assign rvalid0 = rd_pend_q && !rd_port_q;
   assign rvalid1 = rd_pend_q && rd_port_q;
   // Returning data is shown in the cycle the RAM presents it, then held.
   assign rdata0  = rvalid0 ? mem_data_i : rdata0_q;
   assign rdata1  = rvalid1 ? mem_data_i : rdata1_q;

   // RAM request mux; port 0 values are parked on the bus when nobody accesses
   always_comb begin
      mem_addr   = addr0;
      mem_data_o = wdata0;
      mem_WE     = 1'b0;
      if (acc1_s) begin
         mem_addr   = addr1;
         mem_data_o = wdata1;
         mem_WE     = we1;
      end else if (acc0_s) begin
         mem_WE = we0;
      end else begin
         mem_WE = 1'b0;
      end
   end

   // Ownership next-state, fairness bookkeeping and read tagging
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      burst_d   = burst_q;
      rd_pend_d = (acc0_s && !we0) || (acc1_s && !we1);
      rd_port_d = acc1_s;
      case (state_q)
         IDLE: begin
            burst_d = '0;
            if (req0 && req1) begin
               state_d = last_q ? OWN0 : OWN1;
            end else if (req0) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end else begin
               state_d = IDLE;
            end
         end
         OWN0: begin
            if (!req0) begin
               last_d  = 1'b0;
               burst_d = '0;
               state_d = req1 ? OWN1 : IDLE;
            end else if (burst_last_s && req1) begin
               last_d  = 1'b0;
               burst_d = '0;
               state_d = OWN1;
            end else begin
               burst_d = burst_inc_s;
            end
         end
         OWN1: begin
            if (!req1) begin
               last_d  = 1'b1;
               burst_d = '0;
               state_d = req0 ? OWN0 : IDLE;
            end else if (burst_last_s && req0) begin
               last_d  = 1'b1;
               burst_d = '0;
               state_d = OWN0;
            end else begin
               burst_d = burst_inc_s;
            end
         end
         default: begin
            state_d = IDLE;
            burst_d = '0;
         end
      endcase
   end

   // State and return-path registers; reset drops any read in flight
   always_ff @(posedge clk) begin
      if (!arst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         burst_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_port_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         burst_q   <= burst_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
         if (rvalid0) begin
            rdata0_q <= mem_data_i;
         end
         if (rvalid1) begin
            rdata1_q <= mem_data_i;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a tenure/queue-level reference model.
module tb_data_mem_arbiter;

   localparam int MAX_BURST = 4;

   logic       clk = 1'b0;
   logic       arst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_WE;
   logic [7:0] rdata0, rdata1, mem_addr, mem_data_o, mem_data_i;

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   // model: owner -1 = idle, n = accesses made in the current tenure
   int         m_owner = -1;
   int         m_last  = 1;
   int         m_n     = 0;
   bit         m_pend  = 1'b0;
   int         m_pport = 0;
   logic [7:0] m_pdata = 8'h00;
   logic [7:0] m_rd [2] = '{8'h00, 8'h00};

   data_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .arst(arst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
      .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_WE(mem_WE),
      .mem_data_i(mem_data_i)
   );

   always #5 clk = ~clk;

   // synchronous RAM, one-cycle read latency
   always @(posedge clk) begin
      mem_data_i <= ram[mem_addr];
      if (mem_WE) ram[mem_addr] <= mem_data_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // one clock cycle: drive, compare against model, advance model to the next edge
   task automatic cycle(input bit rst_v,
                        input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
      bit         rq [2];
      bit         wq [2];
      logic [7:0] aq [2];
      logic [7:0] dq [2];
      bit         acc;
      bit         exp_we;
      int         o, j;
      @(negedge clk);
      arst = ~rst_v; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      rq = '{r0, r1}; wq = '{w0, w1}; aq = '{a0, a1}; dq = '{d0, d1};
      #1;
      o      = m_owner;
      acc    = (o >= 0) && rq[o];
      exp_we = acc && wq[o];
      check_eq("gnt0", 32'(gnt0), 32'(o == 0));
      check_eq("gnt1", 32'(gnt1), 32'(o == 1));
      check_eq("mem_we", 32'(mem_WE), 32'(exp_we));
      if (acc) check_eq("mem_addr", 32'(mem_addr), 32'(aq[o]));
      if (exp_we) check_eq("mem_wdata", 32'(mem_data_o), 32'(dq[o]));
      check_eq("rvalid0", 32'(rvalid0), 32'(m_pend && m_pport == 0));
      check_eq("rvalid1", 32'(rvalid1), 32'(m_pend && m_pport == 1));
      if (m_pend) m_rd[m_pport] = m_pdata;
      check_eq("rdata0", 32'(rdata0), 32'(m_rd[0]));
      check_eq("rdata1", 32'(rdata1), 32'(m_rd[1]));
      // what the coming edge does
      m_pend = 1'b0;
      if (acc && !wq[o]) begin
         m_pend  = 1'b1;
         m_pport = o;
         m_pdata = ref_mem[aq[o]];
      end
      if (exp_we) ref_mem[aq[o]] = dq[o];
      if (rst_v) begin
         m_owner = -1; m_last = 1; m_n = 0; m_pend = 1'b0;
         m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      end else if (o < 0) begin
         m_n = 0;
         if (rq[0] && rq[1]) m_owner = 1 - m_last;
         else if (rq[0])     m_owner = 0;
         else if (rq[1])     m_owner = 1;
      end else begin
         j = 1 - o;
         if (!rq[o]) begin
            m_last = o; m_n = 0;
            m_owner = rq[j] ? j : -1;
         end else if (m_n == MAX_BURST - 1 && rq[j]) begin
            m_last = o; m_n = 0; m_owner = j;
         end else begin
            m_n++;
         end
      end
   endtask

   initial begin
      bit         r0, r1, rs;
      logic [7:0] a_s;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      ram[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
      arst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
      repeat (2) @(posedge clk);

      // reset held with both requests
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      check_eq("rst_gnt", 32'({gnt0, gnt1, mem_WE, rvalid0, rvalid1}), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      // contention: tenures of MAX_BURST, port 0 first
      for (int k = 0; k < 12; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b0, 8'($urandom), 8'h00);
         check_eq("rr_gnt0", 32'(gnt0), 32'(((k / 4) % 2) == 0));
         check_eq("rr_onehot", 32'(gnt0 && gnt1), 32'd0);
      end
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // single port 1 read of 0x10
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      check_eq("rd_gnt1", 32'(gnt1), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00);
      check_eq("rd_rvalid1", 32'(rvalid1), 32'd1);
      check_eq("rd_rdata1", 32'(rdata1), 32'h0A5);
      check_eq("rd_rvalid0", 32'(rvalid0), 32'd0);

      // port 0 write burst 0x20..0x23
      for (int k = 0; k < 5; k++) begin
         a_s = 8'h20 + 8'((k == 0) ? 0 : k - 1);
         cycle(1'b0, 1'b1, 1'b1, a_s, 8'h11 * 8'((k == 0) ? 1 : k), 1'b0, 1'b0, 8'h00, 8'h00);
         if (k >= 1) begin
            check_eq("wb_we", 32'(mem_WE), 32'd1);
            check_eq("wb_addr", 32'(mem_addr), 32'(8'h20 + 8'(k - 1)));
            check_eq("wb_data", 32'(mem_data_o), 32'(8'h11 * 8'(k)));
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // read back through port 1
      for (int k = 0; k < 6; k++) begin
         a_s = 8'h20 + 8'((k == 0) ? 0 : k - 1);
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, (k < 5), 1'b0, a_s, 8'h00);
         if (k >= 2) begin
            check_eq("rb_rvalid1", 32'(rvalid1), 32'd1);
            check_eq("rb_rdata1", 32'(rdata1), 32'(8'h11 * 8'(k - 1)));
         end
      end

      // handover: port 0 drops while port 1 waits
      cycle(1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
      check_eq("ho_gnt0", 32'(gnt0), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
      check_eq("ho_rvalid0", 32'(rvalid0), 32'd1);
      check_eq("ho_rdata0", 32'(rdata0), 32'h022);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
      check_eq("ho_gnt1", 32'(gnt1), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // reset while a port 0 read is in flight
      cycle(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check_eq("mr_rvalid0", 32'(rvalid0), 32'd0);
      check_eq("mr_gnt0", 32'(gnt0), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check_eq("mr_rvalid0_after", 32'(rvalid0), 32'd0);

      // randomized traffic with sticky requests and rare resets
      r0 = 1'b0; r1 = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(3, 0) == 0) r0 = ~r0;
         if ($urandom_range(3, 0) == 0) r1 = ~r1;
         rs = ($urandom_range(149, 0) == 0);
         cycle(rs, r0, 1'($urandom), 8'($urandom), 8'($urandom),
               r1, 1'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter sharing the single-port data memory between the CPU instruction-cycle controller (port 0) and a debug/DMA loader (port 1). It uses a registered req/gnt handshake and round-robin fairness. Burst ownership is capped at MAX_BURST accesses when the other port is waiting. Read data returns to the owning requester with fixed latency. It sits between the requesters and the synchronous data RAM.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 8, memory data width
MAX_BURST, 4, max consecutive accesses by one owner while the other port requests (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
arst  in  1  reset, synchronous, active-low (0 = reset)
req0  in  1  port 0 (CPU) access request; hold high while accesses are wanted
we0  in  1  port 0 write enable, qualified by req0
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 owns the memory this cycle (registered)
rdata0  out  DATA_WIDTH  port 0 read data
rvalid0  out  1  rdata0 valid (one cycle pulse per read)
req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1  same as port 0, for port 1
mem_addr  out  ADDR_WIDTH  RAM address
mem_data_o  out  DATA_WIDTH  RAM write data
mem_WE  out  1  RAM write enable
mem_data_i  in  DATA_WIDTH  RAM read data, valid one cycle after address (synchronous RAM)

Behaviour:
- Reset (arst=0 at a rising edge): gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, state=IDLE, last=1 (port 0 wins first tie), burst_cnt=0. Any read in flight is dropped; no rvalid follows reset.
- States: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1). At most one gnt is high.
- IDLE: no request -> stay IDLE.
  - Exactly one reqi -> OWNi next cycle.
  - Both requests -> OWN of the port not equal to last.
  - Grant latency is 1 cycle from req sampled high in IDLE.
- Access: one access occurs in every cycle where gnti && reqi.
  - mem_addr=addri, mem_data_o=wdatai, mem_WE=we_i. These are combinational muxes from the owner.
  - With no access: mem_WE=0, mem_addr/mem_data_o hold the port 0 values (don't-care).
- burst_cnt increments on each access and saturates at MAX_BURST. It clears on leaving OWNi.
- OWNi transitions, in priority order:
  - reqi=0: no access that cycle. Next state is OWNj if reqj=1, else IDLE. last<=i.
  - Access occurred, burst_cnt+1==MAX_BURST, and reqj=1: next OWNj, last<=i. This is a forced rotation.
  - Otherwise stay OWNi.
- Handover via reqi=0 costs no dead cycle: OWNi -> OWNj directly.
- Read return: a read access (we=0) in cycle N gives rvalidi=1 and rdatai=mem_data_i in cycle N+1.
  - This holds even if ownership changed at the N/N+1 boundary; the returning port is registered with the access.
  - rdatai holds its last value otherwise.
  - Writes produce no rvalid.
- A requester must not change addr/we/wdata in a granted cycle until the edge that completes the access.
- Simultaneous events: with rotation and reqi dropping in the same cycle, the reqi=0 rule wins (no access).
- MAX_BURST=1 gives strict alternation under contention.

Test Plan:
- Reset: hold arst=0 with req0=req1=1 -> gnt0=gnt1=0, mem_WE=0, rvalid0/1=0. First edge with arst=1 -> next cycle gnt0=1.
- Single port read: port 1 reads addr 0x10 (RAM holds 0xA5) from IDLE -> gnt1 one cycle after req1; rvalid1=1, rdata1=0xA5 one cycle after the access; rvalid0 stays 0.
- Port 0 write burst: req0=1, we0=1, addr0=0x20..0x23, data 0x11..0x44, req1=0 -> 4 consecutive mem_WE pulses with matching addr/data; RAM readback correct.
- Contention rotation (MAX_BURST=4): both req held high from reset -> grant pattern OWN0 x4, OWN1 x4, OWN0 x4; no cycle with both gnt high.
- Handover: port 0 drops req0 while req1=1 -> gnt1 asserts on the next cycle with no idle gap; the last port 0 read still returns rvalid0 on the handover cycle.
- Reset mid-read: arst=0 in the cycle after a port 0 read access -> no rvalid0 pulse afterward; state IDLE, gnt0=0.
